// File: rtl/sym_fir_pkg.sv
// Shared types and elaboration helpers for the symmetric FIR read-side sequencer.
package sym_fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PAIR = 2'd1,
    CTR  = 2'd2,
    FIN  = 2'd3
  } rd_state_t;

  // Address/index width helper: $clog2 with a floor of one bit.
  function automatic int clog2_min1(input int value);
    return ($clog2(value) < 1) ? 1 : $clog2(value);
  endfunction

  function automatic bit cfg_legal(input int num_taps, input int depth);
    return (num_taps >= 2) && (depth >= num_taps) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/ring_addr_sub.sv
// Ring-buffer address subtraction: base - offset with natural W-bit wraparound.
module ring_addr_sub #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_base,
  input  logic [W-1:0] i_offset,
  output logic [W-1:0] o_diff
);

  assign o_diff = i_base - i_offset;

endmodule

// File: rtl/sym_pair_reader.sv
// Symmetric-pair address sequencer for the FIR sample ring buffer.
// Optional stall_cnt output enabled by defining SYM_PAIR_READER_STALL_CNT_EN.
module sym_pair_reader
  import sym_fir_pkg::*;
#(
  parameter  int NUM_TAPS = 16,
  parameter  int DEPTH    = 256,
  localparam int ADDR_W   = clog2_min1(DEPTH),
  localparam int IDX_W    = clog2_min1((NUM_TAPS + 1) / 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] newest_addr,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [IDX_W-1:0]  coef_idx,
  output logic              center,
  output logic              last,
`ifdef SYM_PAIR_READER_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              done
);

  if (!cfg_legal(NUM_TAPS, DEPTH)) begin : g_bad_cfg
    $error("sym_pair_reader: NUM_TAPS must be >= 2 and DEPTH a power of two >= NUM_TAPS");
  end

  localparam bit                ODD    = (NUM_TAPS % 2) == 1;
  localparam logic [IDX_W-1:0]  K_LAST = IDX_W'(NUM_TAPS / 2 - 1);
  localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(NUM_TAPS - 1);

  rd_state_t         r_state;
  logic [ADDR_W-1:0] r_base;
  logic [IDX_W-1:0]  r_k;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic              r_valid;
  logic              r_busy;
  logic              r_center;
  logic              r_last;
  logic              r_done;

  logic [ADDR_W-1:0] w_base;
  logic [IDX_W-1:0]  w_k_next;
  logic [ADDR_W-1:0] w_off_a;
  logic [ADDR_W-1:0] w_off_b;
  logic [ADDR_W-1:0] w_addr_a;
  logic [ADDR_W-1:0] w_addr_b;
  logic              w_handshake;

  // Addresses for the next beat are prepared here and registered on advance;
  // in the CTR beat both offsets collapse to (N-1)/2.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_base   = r_base;
    w_k_next = r_k + 1'b1;
    if (r_state == IDLE) begin
      w_base   = newest_addr;
      w_k_next = '0;
    end
    w_off_a = ADDR_W'(w_k_next);
    w_off_b = SPAN - w_off_a;
  end

  assign w_handshake = r_valid & out_ready;

  ring_addr_sub #(.W(ADDR_W)) u_sub_a (
    .i_base   (w_base),
    .i_offset (w_off_a),
    .o_diff   (w_addr_a)
  );

  ring_addr_sub #(.W(ADDR_W)) u_sub_b (
    .i_base   (w_base),
    .i_offset (w_off_b),
    .o_diff   (w_addr_b)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_base   <= '0;
      r_k      <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_center <= 1'b0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_base   <= newest_addr;
            r_k      <= w_k_next;
            r_addr_a <= w_addr_a;
            r_addr_b <= w_addr_b;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_center <= 1'b0;
            r_last   <= !ODD && (w_k_next == K_LAST);
            r_state  <= PAIR;
          end
        end
        PAIR: begin
          if (w_handshake) begin
            if (r_k == K_LAST && !ODD) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= FIN;
            end else begin
              r_k      <= w_k_next;
              r_addr_a <= w_addr_a;
              r_addr_b <= w_addr_b;
              if (r_k == K_LAST) begin
                r_center <= 1'b1;
                r_last   <= 1'b1;
                r_state  <= CTR;
              end else begin
                r_last <= !ODD && (w_k_next == K_LAST);
              end
            end
          end
        end
        CTR: begin
          if (w_handshake) begin
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_center <= 1'b0;
            r_last   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= FIN;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SYM_PAIR_READER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_state == IDLE && start) begin
      r_stall_cnt <= '0;
    end else if (r_valid && !out_ready && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign addr_a    = r_addr_a;
  assign addr_b    = r_addr_b;
  assign coef_idx  = r_k;
  assign center    = r_center;
  assign last      = r_last;
  assign done      = r_done;

endmodule
